// File: rtl/gpu_display_pkg.sv
// Shared definitions for the GPU display path.
//   state_t        : scan-out fetch FSM encoding (also exported on o_wire_state)
//   BPP_*          : pixel-size codes (log2 of bytes per pixel)
//   DEFAULT_*      : default burst sizing / launch threshold
//   bpp_sanitize() : maps the illegal code 3 onto 4-byte pixels
package gpu_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CALC   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STREAM = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [1:0] BPP_1 = 2'd0;
    localparam logic [1:0] BPP_2 = 2'd1;
    localparam logic [1:0] BPP_4 = 2'd2;

    localparam int DEFAULT_BURST_MAX     = 64;
    localparam int DEFAULT_LAUNCH_THRESH = 48;

    function automatic logic [1:0] bpp_sanitize(input logic [1:0] code);
        return (code == 2'd3) ? BPP_4 : code;
    endfunction

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Burst address/length calculator with one register stage.
//   i_wire_load       : capture a new burst descriptor this cycle
//   i_wire_row_base   : byte address of the current row
//   i_wire_x          : first pixel of the burst within the row
//   i_wire_width      : pixels per row
//   i_wire_bpp_log2   : log2 bytes per pixel (already sanitised)
//   o_wire_address    : row_base + (x << bpp), wraps at ADDR_W
//   o_wire_length     : min(BURST_MAX, width - x), in pixels
// Outputs hold their value until the next load, so the last descriptor
// stays visible for debug after an error.
module painterengine_gpu_burst_calc
    import gpu_display_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 16,
    parameter int BURST_MAX = DEFAULT_BURST_MAX
) (
    input  logic              i_wire_clock,
    input  logic              i_wire_resetn,
    input  logic              i_wire_load,
    input  logic [ADDR_W-1:0] i_wire_row_base,
    input  logic [DIM_W-1:0]  i_wire_x,
    input  logic [DIM_W-1:0]  i_wire_width,
    input  logic [1:0]        i_wire_bpp_log2,
    output logic [ADDR_W-1:0] o_wire_address,
    output logic [ADDR_W-1:0] o_wire_length
);

    localparam logic [DIM_W-1:0] BURST_LIM = DIM_W'(BURST_MAX);

    logic [ADDR_W-1:0] byte_offset;
    logic [DIM_W-1:0]  remain;
    logic [DIM_W-1:0]  burst_len;

    always_comb begin
        byte_offset = ADDR_W'(i_wire_x) << i_wire_bpp_log2;
        remain      = i_wire_width - i_wire_x;
        burst_len   = (remain < BURST_LIM) ? remain : BURST_LIM;
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            o_wire_address <= '0;
            o_wire_length  <= '0;
        end else if (i_wire_load) begin
            o_wire_address <= i_wire_row_base + byte_offset;
            o_wire_length  <= ADDR_W'(burst_len);
        end
    end

endmodule

// File: rtl/painterengine_gpu_scanout_fetch.sv
// Frame-fetch controller: walks a framebuffer row by row, issuing bursts
// to the DMA reader and throttling on downstream FIFO free space.
//   i_wire_enable / i_wire_continuous / i_wire_frame_sync : frame control
//   i_wire_base_address, i_wire_stride, i_wire_width, i_wire_height,
//   i_wire_pixel_bytes_log2 : frame geometry, shadowed at frame start
//   i_wire_fifo_free        : downstream FIFO empty entries
//   i_wire_error_clear      : leaves ERROR
//   o_wire_fifo_flush       : pulse at frame start
//   o_wire_reader_*         : burst descriptor and reader run/reset
//   i_wire_reader_done/error: burst completion status
//   o_wire_busy, o_wire_frame_done, o_wire_error, o_wire_state,
//   o_wire_frame_count      : status
module painterengine_gpu_scanout_fetch
    import gpu_display_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DIM_W         = 16,
    parameter int BURST_MAX     = DEFAULT_BURST_MAX,
    parameter int LAUNCH_THRESH = DEFAULT_LAUNCH_THRESH,
    parameter int CNT_W         = 8
) (
    input  logic              i_wire_clock,
    input  logic              i_wire_resetn,
    input  logic              i_wire_enable,
    input  logic              i_wire_continuous,
    input  logic              i_wire_frame_sync,
    input  logic [ADDR_W-1:0] i_wire_base_address,
    input  logic [DIM_W+1:0]  i_wire_stride,
    input  logic [DIM_W-1:0]  i_wire_width,
    input  logic [DIM_W-1:0]  i_wire_height,
    input  logic [1:0]        i_wire_pixel_bytes_log2,
    input  logic [CNT_W-1:0]  i_wire_fifo_free,
    input  logic              i_wire_error_clear,
    output logic              o_wire_fifo_flush,
    output logic [ADDR_W-1:0] o_wire_reader_address,
    output logic [ADDR_W-1:0] o_wire_reader_length,
    output logic              o_wire_reader_resetn,
    input  logic              i_wire_reader_done,
    input  logic              i_wire_reader_error,
    output logic              o_wire_busy,
    output logic              o_wire_frame_done,
    output logic              o_wire_error,
    output logic [2:0]        o_wire_state,
    output logic [15:0]       o_wire_frame_count
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(LAUNCH_THRESH);

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [DIM_W+1:0]  stride_reg;
    logic [DIM_W-1:0]  width_reg;
    logic [DIM_W-1:0]  height_reg;
    logic [1:0]        bpp_reg;
    logic              cont_reg;
    logic              zero_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [DIM_W-1:0]  x_reg;
    logic [DIM_W-1:0]  y_reg;
    logic              flush_reg;
    logic              reader_resetn_reg;
    logic              frame_done_reg;
    logic [15:0]       frame_count_reg;

    logic              row_end;
    logic [DIM_W-1:0]  y_next;
    logic              frame_end;

    always_comb begin
        row_end   = (x_reg == width_reg);
        y_next    = y_reg + 1'b1;
        frame_end = zero_reg || (row_end && (y_next == height_reg));
    end

    painterengine_gpu_burst_calc #(
        .ADDR_W    (ADDR_W),
        .DIM_W     (DIM_W),
        .BURST_MAX (BURST_MAX)
    ) u_burst_calc (
        .i_wire_clock    (i_wire_clock),
        .i_wire_resetn   (i_wire_resetn),
        .i_wire_load     (state_reg == ST_CALC),
        .i_wire_row_base (row_base_reg),
        .i_wire_x        (x_reg),
        .i_wire_width    (width_reg),
        .i_wire_bpp_log2 (bpp_reg),
        .o_wire_address  (o_wire_reader_address),
        .o_wire_length   (o_wire_reader_length)
    );

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_reg         <= ST_IDLE;
            base_reg          <= '0;
            stride_reg        <= '0;
            width_reg         <= '0;
            height_reg        <= '0;
            bpp_reg           <= '0;
            cont_reg          <= 1'b0;
            zero_reg          <= 1'b0;
            row_base_reg      <= '0;
            x_reg             <= '0;
            y_reg             <= '0;
            flush_reg         <= 1'b0;
            reader_resetn_reg <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_count_reg   <= '0;
        end else begin
            // Pulses and the reader run bit default low; only STREAM keeps
            // the reader running.
            flush_reg         <= 1'b0;
            frame_done_reg    <= 1'b0;
            reader_resetn_reg <= 1'b0;
            if (!i_wire_enable) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (i_wire_frame_sync) begin
                            state_reg <= ST_LATCH;
                            flush_reg <= 1'b1;
                        end
                    end
                    ST_LATCH: begin
                        base_reg     <= i_wire_base_address;
                        stride_reg   <= i_wire_stride;
                        width_reg    <= i_wire_width;
                        height_reg   <= i_wire_height;
                        bpp_reg      <= bpp_sanitize(i_wire_pixel_bytes_log2);
                        cont_reg     <= i_wire_continuous;
                        row_base_reg <= i_wire_base_address;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        // Empty frames skip the reader entirely and complete
                        // straight out of NEXT.
                        zero_reg     <= (i_wire_width == '0) || (i_wire_height == '0);
                        state_reg    <= ((i_wire_width == '0) || (i_wire_height == '0))
                                        ? ST_NEXT : ST_CALC;
                    end
                    ST_CALC: begin
                        state_reg <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (i_wire_fifo_free >= THRESH) begin
                            state_reg         <= ST_STREAM;
                            reader_resetn_reg <= 1'b1;
                        end
                    end
                    ST_STREAM: begin
                        if (i_wire_reader_error) begin
                            state_reg <= ST_ERROR;
                        end else if (i_wire_reader_done) begin
                            x_reg     <= x_reg + o_wire_reader_length[DIM_W-1:0];
                            state_reg <= ST_NEXT;
                        end else begin
                            reader_resetn_reg <= 1'b1;
                        end
                    end
                    ST_NEXT: begin
                        if (row_end) begin
                            x_reg        <= '0;
                            y_reg        <= y_next;
                            row_base_reg <= row_base_reg + ADDR_W'(stride_reg);
                        end
                        if (frame_end) begin
                            frame_done_reg  <= 1'b1;
                            frame_count_reg <= frame_count_reg + 16'd1;
                            state_reg       <= cont_reg ? ST_IDLE : ST_DONE;
                        end else begin
                            state_reg <= ST_CALC;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_DONE;
                    end
                    ST_ERROR: begin
                        if (i_wire_error_clear) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_wire_fifo_flush    = flush_reg;
    assign o_wire_reader_resetn = reader_resetn_reg;
    assign o_wire_frame_done    = frame_done_reg;
    assign o_wire_frame_count   = frame_count_reg;
    assign o_wire_state         = state_reg;
    assign o_wire_error         = (state_reg == ST_ERROR);
    assign o_wire_busy          = (state_reg != ST_IDLE) && (state_reg != ST_DONE)
                                  && (state_reg != ST_ERROR);

endmodule

// File: tb/tb_painterengine_gpu_scanout_fetch.sv
module tb_painterengine_gpu_scanout_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        continuous;
    logic        frame_sync;
    logic [31:0] base_address;
    logic [17:0] stride;
    logic [15:0] width;
    logic [15:0] height;
    logic [1:0]  bpp_log2;
    logic [7:0]  fifo_free;
    logic        error_clear;
    logic        fifo_flush;
    logic [31:0] reader_address;
    logic [31:0] reader_length;
    logic        reader_resetn;
    logic        reader_done;
    logic        reader_error;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [2:0]  state;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    painterengine_gpu_scanout_fetch dut (
        .i_wire_clock            (clk),
        .i_wire_resetn           (resetn),
        .i_wire_enable           (enable),
        .i_wire_continuous       (continuous),
        .i_wire_frame_sync       (frame_sync),
        .i_wire_base_address     (base_address),
        .i_wire_stride           (stride),
        .i_wire_width            (width),
        .i_wire_height           (height),
        .i_wire_pixel_bytes_log2 (bpp_log2),
        .i_wire_fifo_free        (fifo_free),
        .i_wire_error_clear      (error_clear),
        .o_wire_fifo_flush       (fifo_flush),
        .o_wire_reader_address   (reader_address),
        .o_wire_reader_length    (reader_length),
        .o_wire_reader_resetn    (reader_resetn),
        .i_wire_reader_done      (reader_done),
        .i_wire_reader_error     (reader_error),
        .o_wire_busy             (busy),
        .o_wire_frame_done       (frame_done),
        .o_wire_error            (err),
        .o_wire_state            (state),
        .o_wire_frame_count      (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 40 && state !== s; i++) tick();
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    // Waits for STREAM, checks the descriptor, then completes the burst.
    // Returns with the FSM in NEXT.
    task automatic burst(input logic [31:0] a, input logic [31:0] l, input string tag);
        wait_state(3'd4, {tag, "_stream"});
        check({tag, "_rstn"}, {31'd0, reader_resetn}, 32'd1);
        check({tag, "_addr"}, reader_address, a);
        check({tag, "_len"}, reader_length, l);
        $display("burst %s addr=%0h len=%0d", tag, reader_address, reader_length);
        reader_done = 1'b1;
        tick();
        reader_done = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; continuous = 1'b0; frame_sync = 1'b0;
        base_address = 32'h1000; stride = 18'd16; width = 16'd4; height = 16'd2;
        bpp_log2 = 2'd2; fifo_free = 8'd100; error_clear = 1'b0;
        reader_done = 1'b0; reader_error = 1'b0;
        repeat (3) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_rstn", {31'd0, reader_resetn}, 32'd0);
        check("rst_count", {16'd0, frame_count}, 32'd0);
        check("rst_addr", reader_address, 32'd0);
        check("rst_flush", {31'd0, fifo_flush}, 32'd0);
        resetn = 1'b1;
        enable = 1'b1;
        tick();

        // 4x2 frame, 4-byte pixels, stride 16
        pulse_sync();
        check("t1_latch", {29'd0, state}, 32'd1);
        check("t1_flush", {31'd0, fifo_flush}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1_calc", {29'd0, state}, 32'd2);
        tick();
        check("t1_wait", {29'd0, state}, 32'd3);
        check("t1_wait_rstn", {31'd0, reader_resetn}, 32'd0);
        burst(32'h1000, 32'd4, "t1_b0");
        burst(32'h1010, 32'd4, "t1_b1");
        tick();
        check("t1_done_state", {29'd0, state}, 32'd6);
        check("t1_fdone", {31'd0, frame_done}, 32'd1);
        check("t1_count", {16'd0, frame_count}, 32'd1);
        tick();
        check("t1_fdone_low", {31'd0, frame_done}, 32'd0);
        check("t1_hold_done", {29'd0, state}, 32'd6);

        // width 100 split into 64 + 36 pixels
        enable = 1'b0; tick();
        check("t2_idle", {29'd0, state}, 32'd0);
        enable = 1'b1; base_address = 32'h2000; width = 16'd100; height = 16'd1;
        pulse_sync();
        burst(32'h2000, 32'd64, "t2_b0");
        burst(32'h2100, 32'd36, "t2_b1");
        tick();
        check("t2_done", {29'd0, state}, 32'd6);
        check("t2_count", {16'd0, frame_count}, 32'd2);

        // FIFO throttle then error+done together on burst 2
        enable = 1'b0; tick();
        enable = 1'b1; base_address = 32'h3000; bpp_log2 = 2'd1;
        pulse_sync();
        burst(32'h3000, 32'd64, "t3_b0");
        fifo_free = 8'd47;
        wait_state(3'd3, "t3_wait");
        repeat (5) tick();
        check("t3_stuck", {29'd0, state}, 32'd3);
        check("t3_stuck_rstn", {31'd0, reader_resetn}, 32'd0);
        check("t3_addr", reader_address, 32'h3080);
        check("t3_len", reader_length, 32'd36);
        fifo_free = 8'd48;
        tick();
        check("t3_launch", {29'd0, state}, 32'd4);
        check("t3_launch_rstn", {31'd0, reader_resetn}, 32'd1);
        reader_error = 1'b1; reader_done = 1'b1;
        tick();
        reader_error = 1'b0; reader_done = 1'b0;
        check("t3_err_state", {29'd0, state}, 32'd7);
        check("t3_err_flag", {31'd0, err}, 32'd1);
        check("t3_err_rstn", {31'd0, reader_resetn}, 32'd0);
        check("t3_err_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("t3_err_hold", {29'd0, state}, 32'd7);
        check("t3_err_addr", reader_address, 32'h3080);
        check("t3_err_len", reader_length, 32'd36);
        check("t3_err_count", {16'd0, frame_count}, 32'd2);
        error_clear = 1'b1; tick(); error_clear = 1'b0;
        check("t3_clear", {29'd0, state}, 32'd0);
        check("t3_clear_err", {31'd0, err}, 32'd0);
        fifo_free = 8'd100;

        // continuous mode, 2x2 frames, three syncs
        continuous = 1'b1; base_address = 32'h4000; stride = 18'd8;
        width = 16'd2; height = 16'd2; bpp_log2 = 2'd0;
        for (int f = 0; f < 3; f++) begin
            pulse_sync();
            check("t4_flush", {31'd0, fifo_flush}, 32'd1);
            burst(32'h4000, 32'd2, "t4_b0");
            if (f == 0) begin
                wait_state(3'd4, "t4_stream");
                frame_sync = 1'b1; tick(); frame_sync = 1'b0;
                check("t4_sync_ignored", {29'd0, state}, 32'd4);
                check("t4_sync_noflush", {31'd0, fifo_flush}, 32'd0);
                check("t4_b1_addr", reader_address, 32'h4008);
                reader_done = 1'b1; tick(); reader_done = 1'b0;
            end else begin
                burst(32'h4008, 32'd2, "t4_b1");
            end
            tick();
            check("t4_idle", {29'd0, state}, 32'd0);
            check("t4_fdone", {31'd0, frame_done}, 32'd1);
            check("t4_count", {16'd0, frame_count}, 32'(3 + f));
        end

        // zero-width frame: no reader activity
        continuous = 1'b0; width = 16'd0;
        pulse_sync();
        check("t5_latch", {29'd0, state}, 32'd1);
        tick();
        check("t5_next", {29'd0, state}, 32'd5);
        check("t5_rstn", {31'd0, reader_resetn}, 32'd0);
        check("t5_fdone_early", {31'd0, frame_done}, 32'd0);
        tick();
        check("t5_done", {29'd0, state}, 32'd6);
        check("t5_fdone", {31'd0, frame_done}, 32'd1);
        check("t5_count", {16'd0, frame_count}, 32'd6);

        // enable drop mid-STREAM
        enable = 1'b0; tick();
        enable = 1'b1; base_address = 32'h5000; width = 16'd4; height = 16'd1; bpp_log2 = 2'd2;
        pulse_sync();
        wait_state(3'd4, "t6_stream");
        check("t6_addr", reader_address, 32'h5000);
        enable = 1'b0;
        tick();
        check("t6_rstn", {31'd0, reader_resetn}, 32'd0);
        check("t6_idle", {29'd0, state}, 32'd0);
        check("t6_fdone", {31'd0, frame_done}, 32'd0);
        tick();
        check("t6_count", {16'd0, frame_count}, 32'd6);

        // asynchronous reset mid-burst
        enable = 1'b1;
        pulse_sync();
        wait_state(3'd4, "t7_stream");
        #2 resetn = 1'b0;
        #1;
        check("t7_rstn", {31'd0, reader_resetn}, 32'd0);
        check("t7_state", {29'd0, state}, 32'd0);
        check("t7_count", {16'd0, frame_count}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
